// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with byte lanes, wait states, ERROR responses and write-to-read forwarding
module ahb_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hrst_n,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(BYTES);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx, low_mask;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data, wr_word;
  logic [ADDR_WIDTH-1:0] full_idx;
  logic [AW-1:0] wr_idx, ridx;
  logic [BYTES-1:0] wr_mask, mask;
  logic wr_pend, acc, err, commit, unused_ok;
  assign hreadyout = state == ST_IDLE || state == ST_ERR2;
  assign hresp = state == ST_ERR1 || state == ST_ERR2;
  assign acc = hsel & hready & htrans[1] & hreadyout;
  assign commit = hreadyout & wr_pend;
  assign full_idx = haddr >> OFFW;
  assign ridx = full_idx[AW-1:0];
  assign low_mask = (3'd1 << hsize) - 3'd1;
  assign err = (full_idx >= ADDR_WIDTH'(MEM_DEPTH)) || (|(haddr[2:0] & low_mask)) || (hsize > 3'(OFFW));
  assign unused_ok = ^{hburst, htrans[0]};
  // A read accepted on the edge that completes a write to the same word sees the new lanes
  always_comb begin
    mask = '0;
    rd_data = mem[ridx];
    wr_word = mem[wr_idx];
    for (int b = 0; b < BYTES; b++) begin
      mask[b] = b >= int'(haddr[OFFW-1:0]) && b < int'(haddr[OFFW-1:0]) + (1 << hsize);
      rd_data[8*b +: 8] = (commit && wr_idx == ridx && wr_mask[b]) ? hwdata[8*b +: 8] : rd_data[8*b +: 8];
      wr_word[8*b +: 8] = wr_mask[b] ? hwdata[8*b +: 8] : wr_word[8*b +: 8];
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (hreadyout) begin
      state_nx = !acc ? ST_IDLE : err ? ST_ERR1 : (WAIT_STATES > 0) ? ST_WAIT : ST_IDLE;
      cnt_nx = 3'(WAIT_STATES);
    end else if (state == ST_WAIT) begin
      cnt_nx = cnt - 3'd1;
      state_nx = cnt == 3'd1 ? ST_IDLE : ST_WAIT;
    end else
      state_nx = ST_ERR2;
  end
  always_ff @(posedge hclk or negedge hrst_n)
    if (!hrst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      wr_pend <= 1'b0;
      wr_idx <= '0;
      wr_mask <= '0;
      hrdata <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (hreadyout) begin
        wr_pend <= acc & hwrite & ~err;
        wr_idx <= ridx;
        wr_mask <= mask;
        if (acc && !hwrite && !err) hrdata <= rd_data;
      end
    end
  always_ff @(posedge hclk)
    if (commit) mem[wr_idx] <= wr_word;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: table-driven AHB transfers on a zero-wait and a three-wait instance, scoreboarded per data phase
module tb_ahb_sram_slave;
  typedef struct {
    logic d3; logic sel; logic [1:0] trans; logic wr; logic [2:0] size;
    logic [31:0] addr; logic [31:0] wdata; logic err; logic chk; logic [31:0] data;
  } vec_t;
  typedef struct { logic err; logic chk; logic [31:0] data; int waits; } exp_t;

  logic hclk = 0, hrst_n = 0, sel = 0, use3 = 0, hwrite = 0, mon_en = 1;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [1:0] htrans = 0;
  logic [2:0] hsize = 0, hburst = 0;
  logic hready_bus, hsel0, hsel3;
  logic hreadyout0, hresp0, hreadyout3, hresp3;
  logic [31:0] hrdata0, hrdata3;
  int checks = 0, errs = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  always #5 hclk = ~hclk;
  assign hsel0 = sel & ~use3;
  assign hsel3 = sel & use3;
  assign hready_bus = use3 ? hreadyout3 : hreadyout0;

  ahb_sram_slave u0 (.hclk(hclk), .hrst_n(hrst_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hready(hready_bus), .hwdata(hwdata),
    .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0));
  ahb_sram_slave #(.WAIT_STATES(3)) u3 (.hclk(hclk), .hrst_n(hrst_n), .hsel(hsel3), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hready(hready_bus),
    .hwdata(hwdata), .hreadyout(hreadyout3), .hresp(hresp3), .hrdata(hrdata3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(logic d3, logic s, logic [1:0] t, logic w, logic [2:0] sz,
      logic [31:0] a, logic [31:0] wd, logic e, logic c, logic [31:0] d);
    return '{d3, s, t, w, sz, a, wd, e, c, d};
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge hclk);
    while (!hready_bus && n < 20) begin
      n++;
      @(negedge hclk);
    end
    if (!hready_bus) chk("hready_timeout", 32'(hready_bus), 32'd1);
  endtask

  task automatic issue(input vec_t x);
    use3 = x.d3; sel = x.sel; htrans = x.trans; hwrite = x.wr; hsize = x.size; haddr = x.addr;
    hburst = x.d3 ? 3'd3 : 3'd1;
    if (x.sel && x.trans[1]) exp_q.push_back('{x.err, x.chk, x.data, x.err ? 1 : (x.d3 ? 3 : 0)});
    wait_ready();
    @(posedge hclk); #1;
    hwdata = x.wdata;
  endtask

  task automatic drain();
    htrans = 2'd0; sel = 1'b0;
    wait_ready();
    @(posedge hclk); #1;
  endtask

  // Monitor: one scoreboard pop per completed data phase, wait cycles counted while hreadyout is low
  initial begin
    logic dp, hr, hrsp;
    logic [31:0] rd;
    int waits;
    exp_t e;
    dp = 0; waits = 0;
    forever begin
      @(negedge hclk);
      hr = hready_bus;
      hrsp = use3 ? hresp3 : hresp0;
      rd = use3 ? hrdata3 : hrdata0;
      if (!mon_en) begin
        dp = 0; waits = 0; exp_q.delete();
      end else if (dp && !hr) begin
        waits++;
        if (exp_q.size() != 0) chk("hresp_stall", 32'(hrsp), 32'(exp_q[0].err));
      end else begin
        if (dp) begin
          if (exp_q.size() == 0) chk("unexpected_data_phase", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("hresp", 32'(hrsp), 32'(e.err));
            chk("wait_cycles", 32'(waits), 32'(e.waits));
            if (e.chk) chk("hrdata", rd, e.data);
          end
        end
        waits = 0;
        dp = sel & htrans[1] & hr;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back(v(0,1,2,1,2,32'h10,32'hDEADBEEF,0,0,0));
    vecs.push_back(v(0,1,2,0,2,32'h10,0,0,1,32'hDEADBEEF));
    vecs.push_back(v(0,1,2,1,0,32'h13,32'hAB5A5A5A,0,0,0));
    vecs.push_back(v(0,1,0,0,2,32'h10,0,0,0,0));
    vecs.push_back(v(0,1,2,0,2,32'h10,0,0,1,32'hABADBEEF));
    vecs.push_back(v(0,1,2,1,2,32'h20,32'h11223344,0,0,0));
    vecs.push_back(v(0,1,2,0,2,32'h20,0,0,1,32'h11223344));
    vecs.push_back(v(0,0,2,1,2,32'h20,32'hFFFFFFFF,0,0,0));
    vecs.push_back(v(0,1,1,1,2,32'h20,32'hFFFFFFFF,0,0,0));
    vecs.push_back(v(0,1,2,0,2,32'h1000,0,1,1,32'h11223344));
    vecs.push_back(v(0,1,2,0,1,32'h01,0,1,1,32'h11223344));
    vecs.push_back(v(0,1,2,0,2,32'h10,0,0,1,32'hABADBEEF));
    vecs.push_back(v(0,1,2,1,1,32'h22,32'hBEEF7777,0,0,0));
    vecs.push_back(v(0,1,2,0,2,32'h20,0,0,1,32'hBEEF3344));
    vecs.push_back(v(0,1,2,0,3,32'h18,0,1,1,32'hBEEF3344));
    vecs.push_back(v(0,1,2,1,0,32'h11,32'h5A5ACD5A,0,0,0));
    vecs.push_back(v(0,1,2,0,2,32'h10,0,0,1,32'hABADCDEF));
    vecs.push_back(v(0,1,2,1,2,32'h22,32'hFFFFFFFF,1,1,32'hABADCDEF));
    vecs.push_back(v(0,1,2,0,2,32'h20,0,0,1,32'hBEEF3344));
    vecs.push_back(v(0,1,2,0,0,32'h23,0,0,1,32'hBEEF3344));
    vecs.push_back(v(1,1,2,1,2,32'h40,32'hA0000001,0,0,0));
    vecs.push_back(v(1,1,3,1,2,32'h44,32'hA0000002,0,0,0));
    vecs.push_back(v(1,1,3,1,2,32'h48,32'hA0000003,0,0,0));
    vecs.push_back(v(1,1,3,1,2,32'h4C,32'hA0000004,0,0,0));
    vecs.push_back(v(1,1,2,0,2,32'h40,0,0,1,32'hA0000001));
    vecs.push_back(v(1,1,3,0,2,32'h44,0,0,1,32'hA0000002));
    vecs.push_back(v(1,1,3,0,2,32'h48,0,0,1,32'hA0000003));
    vecs.push_back(v(1,1,3,0,2,32'h4C,0,0,1,32'hA0000004));
    vecs.push_back(v(1,1,2,0,2,32'h1000,0,1,1,32'hA0000004));
    vecs.push_back(v(1,1,2,1,2,32'h50,32'h12121212,0,0,0));
    vecs.push_back(v(1,1,2,0,2,32'h50,0,0,1,32'h12121212));

    repeat (3) @(posedge hclk);
    #1;
    chk("rst_hreadyout0", 32'(hreadyout0), 32'd1);
    chk("rst_hresp0", 32'(hresp0), 32'd0);
    chk("rst_hrdata0", hrdata0, 32'd0);
    chk("rst_hreadyout3", 32'(hreadyout3), 32'd1);
    chk("rst_hresp3", 32'(hresp3), 32'd0);
    chk("rst_hrdata3", hrdata3, 32'd0);
    @(negedge hclk) hrst_n = 1;
    @(posedge hclk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0 && vecs[i].d3 != vecs[i-1].d3) drain();
      issue(vecs[i]);
    end
    drain();

    // Reset asserted while the wait-state instance is stalling a write data phase
    mon_en = 0;
    @(posedge hclk); #1;
    use3 = 1; sel = 1; htrans = 2'd2; hwrite = 1; hsize = 3'd2; haddr = 32'h50;
    wait_ready();
    @(posedge hclk); #1;
    htrans = 2'd0; sel = 0; hwdata = 32'h77777777;
    @(negedge hclk);
    chk("wait_phase_low", 32'(hreadyout3), 32'd0);
    hrst_n = 0;
    #1;
    chk("midrst_hreadyout", 32'(hreadyout3), 32'd1);
    chk("midrst_hresp", 32'(hresp3), 32'd0);
    chk("midrst_hrdata", hrdata3, 32'd0);
    repeat (2) @(posedge hclk);
    @(negedge hclk) hrst_n = 1;
    @(posedge hclk); #1;
    mon_en = 1;
    @(posedge hclk); #1;
    issue(v(1,1,2,0,2,32'h50,0,0,1,32'h12121212));
    drain();
    repeat (2) @(posedge hclk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
